// File: rtl/dec_gpr_wbq_pkg.sv
// Shared types for the GPR writeback queue.
// DEC_WBQ_ONEHOT_STORE_EN adds a stored one-hot destination to each entry.
package dec_wbq_pkg;

  localparam int GPR_NUM = 32;
  localparam int GPR_AW  = 5;

  typedef struct packed {
    logic                valid;
    logic [GPR_AW-1:0]   addr;
    logic [31:0]         data;
`ifdef DEC_WBQ_ONEHOT_STORE_EN
    logic [GPR_NUM-1:0]  onehot;
`endif
  } wbq_entry_t;

endpackage

// File: rtl/dec_gpr_wbq_if.sv
// Producer/regfile-side bundle of the writeback queue: push handshake,
// drain control, port-2 write signals and the pending scoreboard.
interface dec_gpr_wbq_if
  import dec_wbq_pkg::*;
#(
  parameter int DEPTH_LOG2 = 2
) ();

  logic                  push_valid;
  logic [GPR_AW-1:0]     push_addr;
  logic [31:0]           push_data;
  logic                  push_ready;
  logic                  port_free;
  logic                  flush;
  logic                  wen2;
  logic [GPR_AW-1:0]     waddr2;
  logic [GPR_NUM-1:0]    waddr2_onehot;
  logic [31:0]           wd2;
  logic [GPR_NUM-1:0]    pending;
  logic [DEPTH_LOG2:0]   count;

  modport master (
    output push_valid, push_addr, push_data, port_free, flush,
    input  push_ready, wen2, waddr2, waddr2_onehot, wd2, pending, count
  );

  modport slave (
    input  push_valid, push_addr, push_data, port_free, flush,
    output push_ready, wen2, waddr2, waddr2_onehot, wd2, pending, count
  );

endinterface

// File: rtl/dec_gpr_wbq_onehot_dec.sv
// 5-to-32 GPR address decoder; bit 0 is never set because x0 is not writable.
module dec_wbq_onehot_dec
  import dec_wbq_pkg::*;
(
  input  logic [GPR_AW-1:0]  addr,
  output logic [GPR_NUM-1:0] onehot
);

  // Decode every nonzero GPR index.
  always_comb begin
    onehot = {GPR_NUM{1'b0}};
    for (int i = 1; i < GPR_NUM; i++) begin
      if (addr == GPR_AW'(i)) begin
        onehot[i] = 1'b1;
      end else begin
        onehot[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/dec_gpr_wbq.sv
// Writeback queue in front of GPR write port 2, with a per-GPR pending scoreboard.
// Build option DEC_WBQ_ONEHOT_STORE_EN stores decoded one-hot addresses per entry.
module dec_gpr_wbq
  import dec_wbq_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int DEPTH_LOG2 = 2
) (
  input logic          clk,
  input logic          rst_l,
  dec_gpr_wbq_if.slave bus
);

  localparam logic [DEPTH_LOG2:0]   FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_ZERO = (DEPTH_LOG2+1)'(0);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ZERO = DEPTH_LOG2'(0);

  wbq_entry_t              entry_r [DEPTH];
  logic [DEPTH_LOG2-1:0]   rd_ptr_r;
  logic [DEPTH_LOG2-1:0]   wr_ptr_r;
  logic [DEPTH_LOG2:0]     count_r;

  wbq_entry_t              head_s;
  logic                    push_ready_s;
  logic                    store_s;
  logic                    pop_s;
  logic [GPR_NUM-1:0]      head_onehot_s;
  logic [GPR_NUM-1:0]      entry_onehot_s [DEPTH];
  logic [GPR_NUM-1:0]      pending_s;
  logic [GPR_AW-1:0]       waddr2_s;
  logic [GPR_NUM-1:0]      waddr2_onehot_s;
  logic [31:0]             wd2_s;

  assign head_s       = entry_r[rd_ptr_r];
  assign push_ready_s = (count_r != FULL_CNT);
  // x0 pushes complete the handshake but are never stored.
  assign store_s      = bus.push_valid & push_ready_s & ~bus.flush & (bus.push_addr != 5'd0);
  assign pop_s        = (count_r != CNT_ZERO) & bus.port_free & ~bus.flush;

`ifdef DEC_WBQ_ONEHOT_STORE_EN
  logic [GPR_NUM-1:0] push_onehot_s;

  dec_wbq_onehot_dec u_push_dec (
    .addr   (bus.push_addr),
    .onehot (push_onehot_s)
  );

  assign head_onehot_s = head_s.onehot;

  for (genvar g = 0; g < DEPTH; g++) begin : g_stored_onehot
    assign entry_onehot_s[g] = entry_r[g].onehot;
  end
`else
  dec_wbq_onehot_dec u_head_dec (
    .addr   (head_s.addr),
    .onehot (head_onehot_s)
  );

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry_dec
    dec_wbq_onehot_dec u_entry_dec (
      .addr   (entry_r[g].addr),
      .onehot (entry_onehot_s[g])
    );
  end
`endif

  // Scoreboard: OR of one-hot destinations over all valid entries.
  always_comb begin
    pending_s = {GPR_NUM{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      pending_s = pending_s | (entry_onehot_s[i] & {GPR_NUM{entry_r[i].valid}});
    end
  end

  // Port-2 write signals, held at zero whenever no write is issued.
  always_comb begin
    if (pop_s) begin
      waddr2_s        = head_s.addr;
      waddr2_onehot_s = head_onehot_s;
      wd2_s           = head_s.data;
    end else begin
      waddr2_s        = 5'd0;
      waddr2_onehot_s = {GPR_NUM{1'b0}};
      wd2_s           = 32'h0;
    end
  end

  // Queue storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rd_ptr_r <= PTR_ZERO;
      wr_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
      for (int i = 0; i < DEPTH; i++) begin
        entry_r[i] <= '0;
      end
    end else if (bus.flush) begin
      rd_ptr_r <= PTR_ZERO;
      wr_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
      for (int i = 0; i < DEPTH; i++) begin
        entry_r[i] <= '0;
      end
    end else begin
      if (store_s) begin
        entry_r[wr_ptr_r].valid  <= 1'b1;
        entry_r[wr_ptr_r].addr   <= bus.push_addr;
        entry_r[wr_ptr_r].data   <= bus.push_data;
`ifdef DEC_WBQ_ONEHOT_STORE_EN
        entry_r[wr_ptr_r].onehot <= push_onehot_s;
`endif
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      // Store and pop never share a slot: that needs count 0 or DEPTH.
      if (pop_s) begin
        entry_r[rd_ptr_r].valid <= 1'b0;
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      count_r <= count_r + (store_s ? CNT_ONE : CNT_ZERO) - (pop_s ? CNT_ONE : CNT_ZERO);
    end
  end

  assign bus.push_ready    = push_ready_s;
  assign bus.wen2          = pop_s;
  assign bus.waddr2        = waddr2_s;
  assign bus.waddr2_onehot = waddr2_onehot_s;
  assign bus.wd2           = wd2_s;
  assign bus.pending       = pending_s;
  assign bus.count         = count_r;

endmodule

// File: tb/tb_dec_gpr_wbq.sv
// Self-checking bench for dec_gpr_wbq: directed scenarios plus randomized
// traffic checked against a queue-based reference model.
module tb_dec_gpr_wbq;
  import dec_wbq_pkg::*;

  localparam int DEPTH      = 4;
  localparam int DEPTH_LOG2 = 2;

  logic clk = 1'b0;
  logic rst_l;
  always #5 clk = ~clk;

  dec_gpr_wbq_if #(.DEPTH_LOG2(DEPTH_LOG2)) bus ();

  dec_gpr_wbq #(.DEPTH(DEPTH), .DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clk   (clk),
    .rst_l (rst_l),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;
  wr_t model_q[$];

  function automatic logic [31:0] model_pending();
    logic [31:0] p;
    p = 32'h0;
    foreach (model_q[i]) p = p | (32'h1 << model_q[i].addr);
    return p;
  endfunction

  task automatic drive(input logic v, input logic [4:0] a, input logic [31:0] d,
                       input logic pf, input logic fl);
    bus.push_valid = v;
    bus.push_addr  = a;
    bus.push_data  = d;
    bus.port_free  = pf;
    bus.flush      = fl;
  endtask

  // One clock edge; the model consumes the inputs that were stable across it.
  task automatic tick();
    bit acc;
    wr_t e;
    @(posedge clk);
    if (!rst_l || bus.flush) begin
      model_q.delete();
    end else begin
      acc = bus.push_valid && (model_q.size() != DEPTH) && (bus.push_addr != 5'd0);
      if (model_q.size() != 0 && bus.port_free) void'(model_q.pop_front());
      if (acc) begin
        e.addr = bus.push_addr;
        e.data = bus.push_data;
        model_q.push_back(e);
      end
    end
    #2;
  endtask

  task automatic test_reset();
    rst_l = 1'b0;
    drive(1'b1, 5'd3, 32'h1234_5678, 1'b1, 1'b0);
    #3;
    n_checks++; if (bus.push_ready !== 1'b1) begin n_errors++; $display("FAIL reset_push_ready got %b want 1", bus.push_ready); end
    n_checks++; if (bus.wen2 !== 1'b0) begin n_errors++; $display("FAIL reset_wen2 got %b want 0", bus.wen2); end
    n_checks++; if (bus.waddr2 !== 5'd0) begin n_errors++; $display("FAIL reset_waddr2 got %0d want 0", bus.waddr2); end
    n_checks++; if (bus.waddr2_onehot !== 32'h0) begin n_errors++; $display("FAIL reset_onehot got %h want 0", bus.waddr2_onehot); end
    n_checks++; if (bus.wd2 !== 32'h0) begin n_errors++; $display("FAIL reset_wd2 got %h want 0", bus.wd2); end
    n_checks++; if (bus.pending !== 32'h0) begin n_errors++; $display("FAIL reset_pending got %h want 0", bus.pending); end
    n_checks++; if (bus.count !== 3'd0) begin n_errors++; $display("FAIL reset_count got %0d want 0", bus.count); end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst_l = 1'b1;
    model_q.delete();
    tick();
  endtask

  task automatic test_basic();
    drive(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b1, 1'b0);
    #1;
    n_checks++; if (bus.wen2 !== 1'b0) begin n_errors++; $display("FAIL basic_no_bypass got %b want 0", bus.wen2); end
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    #1;
    n_checks++; if (bus.wen2 !== 1'b1) begin n_errors++; $display("FAIL basic_wen2 got %b want 1", bus.wen2); end
    n_checks++; if (bus.waddr2 !== 5'd5) begin n_errors++; $display("FAIL basic_waddr2 got %0d want 5", bus.waddr2); end
    n_checks++; if (bus.waddr2_onehot !== 32'h0000_0020) begin n_errors++; $display("FAIL basic_onehot got %h want 00000020", bus.waddr2_onehot); end
    n_checks++; if (bus.wd2 !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL basic_wd2 got %h want deadbeef", bus.wd2); end
    n_checks++; if (bus.pending !== 32'h0000_0020) begin n_errors++; $display("FAIL basic_pending_pop got %h want 00000020", bus.pending); end
    tick();
    #1;
    n_checks++; if (bus.count !== 3'd0) begin n_errors++; $display("FAIL basic_count got %0d want 0", bus.count); end
    n_checks++; if (bus.pending !== 32'h0) begin n_errors++; $display("FAIL basic_pending got %h want 0", bus.pending); end
  endtask

  task automatic test_fill_hold();
    logic [4:0] exp_addr [5];
    exp_addr = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd9};
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 5'(i), 32'h100 + 32'(i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 5'd9, 32'h109, 1'b0, 1'b0);
    #1;
    n_checks++; if (bus.count !== 3'd4) begin n_errors++; $display("FAIL fill_count got %0d want 4", bus.count); end
    n_checks++; if (bus.push_ready !== 1'b0) begin n_errors++; $display("FAIL fill_ready got %b want 0", bus.push_ready); end
    n_checks++; if (bus.pending !== 32'h0000_001E) begin n_errors++; $display("FAIL fill_pending got %h want 0000001e", bus.pending); end
    tick();
    #1;
    n_checks++; if (bus.count !== 3'd4) begin n_errors++; $display("FAIL fill_held_count got %0d want 4", bus.count); end
    drive(1'b1, 5'd9, 32'h109, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      #1;
      n_checks++; if (bus.push_ready !== (k != 0)) begin n_errors++; $display("FAIL fill_ready_drain%0d got %b want %b", k, bus.push_ready, (k != 0)); end
      n_checks++; if (bus.wen2 !== 1'b1) begin n_errors++; $display("FAIL fill_wen2_%0d got %b want 1", k, bus.wen2); end
      n_checks++; if (bus.waddr2 !== exp_addr[k]) begin n_errors++; $display("FAIL fill_order_%0d got %0d want %0d", k, bus.waddr2, exp_addr[k]); end
      n_checks++; if (bus.wd2 !== (32'h100 + 32'(exp_addr[k]))) begin n_errors++; $display("FAIL fill_data_%0d got %h want %h", k, bus.wd2, 32'h100 + 32'(exp_addr[k])); end
      tick();
      if (k == 1) drive(1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    end
    #1;
    n_checks++; if (bus.count !== 3'd0) begin n_errors++; $display("FAIL fill_empty got %0d want 0", bus.count); end
  endtask

  task automatic test_addr0();
    drive(1'b1, 5'd0, 32'hCAFE_0000, 1'b1, 1'b0);
    #1;
    n_checks++; if (bus.push_ready !== 1'b1) begin n_errors++; $display("FAIL x0_ready got %b want 1", bus.push_ready); end
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      #1;
      n_checks++; if (bus.count !== 3'd0) begin n_errors++; $display("FAIL x0_count got %0d want 0", bus.count); end
      n_checks++; if (bus.wen2 !== 1'b0) begin n_errors++; $display("FAIL x0_wen2 got %b want 0", bus.wen2); end
      tick();
    end
  endtask

  task automatic test_same_dest();
    drive(1'b1, 5'd7, 32'hAAAA_0001, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd7, 32'hBBBB_0002, 1'b1, 1'b0);
    #1;
    n_checks++; if (bus.wd2 !== 32'hAAAA_0001 || bus.waddr2 !== 5'd7) begin n_errors++; $display("FAIL same_first got x%0d=%h want x7=aaaa0001", bus.waddr2, bus.wd2); end
    n_checks++; if (bus.pending[7] !== 1'b1) begin n_errors++; $display("FAIL same_pend_a got %b want 1", bus.pending[7]); end
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    #1;
    n_checks++; if (bus.wd2 !== 32'hBBBB_0002 || bus.waddr2 !== 5'd7) begin n_errors++; $display("FAIL same_second got x%0d=%h want x7=bbbb0002", bus.waddr2, bus.wd2); end
    n_checks++; if (bus.pending[7] !== 1'b1) begin n_errors++; $display("FAIL same_pend_b got %b want 1", bus.pending[7]); end
    tick();
    #1;
    n_checks++; if (bus.pending !== 32'h0 || bus.wen2 !== 1'b0) begin n_errors++; $display("FAIL same_done got pend=%h wen=%b want 0/0", bus.pending, bus.wen2); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'(3 + i), 32'h300 + 32'(i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 5'd6, 32'h0666_0666, 1'b1, 1'b1);
    #1;
    n_checks++; if (bus.wen2 !== 1'b0) begin n_errors++; $display("FAIL flush_wen2 got %b want 0", bus.wen2); end
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    #1;
    n_checks++; if (bus.count !== 3'd0) begin n_errors++; $display("FAIL flush_count got %0d want 0", bus.count); end
    n_checks++; if (bus.pending !== 32'h0) begin n_errors++; $display("FAIL flush_pending got %h want 0", bus.pending); end
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++; if (bus.wen2 !== 1'b0) begin n_errors++; $display("FAIL flush_dropped got wen=%b data=%h want no write", bus.wen2, bus.wd2); end
      tick();
    end
  endtask

  task automatic test_reset_mid_drain();
    drive(1'b1, 5'd10, 32'h0A0A_0A0A, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd11, 32'h0B0B_0B0B, 1'b0, 1'b0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    #1;
    n_checks++; if (bus.wen2 !== 1'b1 || bus.waddr2 !== 5'd10) begin n_errors++; $display("FAIL rst_pre got wen=%b a=%0d want 1/10", bus.wen2, bus.waddr2); end
    rst_l = 1'b0;
    #1;
    n_checks++; if (bus.wen2 !== 1'b0) begin n_errors++; $display("FAIL rst_mid_wen2 got %b want 0", bus.wen2); end
    n_checks++; if (bus.count !== 3'd0 || bus.pending !== 32'h0) begin n_errors++; $display("FAIL rst_mid_state got cnt=%0d pend=%h want 0/0", bus.count, bus.pending); end
    n_checks++; if (bus.waddr2 !== 5'd0 || bus.wd2 !== 32'h0 || bus.waddr2_onehot !== 32'h0) begin n_errors++; $display("FAIL rst_mid_bus got a=%0d d=%h oh=%h want 0", bus.waddr2, bus.wd2, bus.waddr2_onehot); end
    n_checks++; if (bus.push_ready !== 1'b1) begin n_errors++; $display("FAIL rst_mid_ready got %b want 1", bus.push_ready); end
    model_q.delete();
    @(negedge clk);
    rst_l = 1'b1;
    tick();
  endtask

  task automatic test_wrap();
    int pushed = 0;
    int cyc = 0;
    logic v = 1'b0;
    logic [4:0] a = 5'd1;
    logic [31:0] d = 32'h0;
    logic pf;
    logic exp_wen;
    while ((pushed < 3 * DEPTH || model_q.size() != 0) && cyc < 300) begin
      if (!v && pushed < 3 * DEPTH) begin
        v = 1'b1;
        a = 5'($urandom_range(1, 31));
        d = $urandom;
      end
      pf = ($urandom_range(0, 2) == 0);
      drive(v, a, d, pf, 1'b0);
      #1;
      exp_wen = (model_q.size() != 0) && pf;
      n_checks++; if (bus.wen2 !== exp_wen) begin n_errors++; $display("FAIL wrap_wen2 got %b want %b", bus.wen2, exp_wen); end
      if (exp_wen) begin
        n_checks++; if (bus.waddr2 !== model_q[0].addr || bus.wd2 !== model_q[0].data) begin n_errors++; $display("FAIL wrap_head got x%0d=%h want x%0d=%h", bus.waddr2, bus.wd2, model_q[0].addr, model_q[0].data); end
      end
      n_checks++; if (bus.count !== 3'(model_q.size())) begin n_errors++; $display("FAIL wrap_count got %0d want %0d", bus.count, model_q.size()); end
      if (v && model_q.size() != DEPTH) begin
        pushed++;
        v = 1'b0;
      end
      tick();
      cyc++;
    end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    n_checks++; if (pushed != 3 * DEPTH || model_q.size() != 0) begin n_errors++; $display("FAIL wrap_timeout got pushed=%0d left=%0d want %0d/0", pushed, model_q.size(), 3 * DEPTH); end
  endtask

  task automatic test_random();
    logic v = 1'b0;
    logic [4:0] a = 5'd0;
    logic [31:0] d = 32'h0;
    logic pf, fl, exp_ready, exp_wen;
    logic [4:0]  exp_addr;
    logic [31:0] exp_oh, exp_data;
    for (int c = 0; c < 600; c++) begin
      if (!v) begin
        v = ($urandom_range(0, 3) != 0);
        a = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        d = $urandom;
      end
      pf = ($urandom_range(0, 2) != 0);
      fl = ($urandom_range(0, 24) == 0);
      drive(v, a, d, pf, fl);
      #1;
      exp_ready = (model_q.size() != DEPTH);
      exp_wen   = (model_q.size() != 0) && pf && !fl;
      exp_addr  = exp_wen ? model_q[0].addr : 5'd0;
      exp_data  = exp_wen ? model_q[0].data : 32'h0;
      exp_oh    = exp_wen ? (32'h1 << model_q[0].addr) : 32'h0;
      n_checks++; if (bus.push_ready !== exp_ready) begin n_errors++; $display("FAIL rnd_ready c%0d got %b want %b", c, bus.push_ready, exp_ready); end
      n_checks++; if (bus.wen2 !== exp_wen) begin n_errors++; $display("FAIL rnd_wen2 c%0d got %b want %b", c, bus.wen2, exp_wen); end
      n_checks++; if (bus.waddr2 !== exp_addr || bus.wd2 !== exp_data) begin n_errors++; $display("FAIL rnd_write c%0d got x%0d=%h want x%0d=%h", c, bus.waddr2, bus.wd2, exp_addr, exp_data); end
      n_checks++; if (bus.waddr2_onehot !== exp_oh) begin n_errors++; $display("FAIL rnd_onehot c%0d got %h want %h", c, bus.waddr2_onehot, exp_oh); end
      n_checks++; if (bus.pending !== model_pending()) begin n_errors++; $display("FAIL rnd_pending c%0d got %h want %h", c, bus.pending, model_pending()); end
      n_checks++; if (bus.count !== 3'(model_q.size())) begin n_errors++; $display("FAIL rnd_count c%0d got %0d want %0d", c, bus.count, model_q.size()); end
      // Producer holds its result until the handshake completes or a flush drops it.
      if (fl || (v && exp_ready)) v = 1'b0;
      tick();
    end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    drive(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    test_reset();
    test_basic();
    test_fill_hold();
    test_addr0();
    test_same_dest();
    test_flush();
    test_reset_mid_drain();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dec_gpr_wbq.md
Name: dec_gpr_wbq

Overview:
- Writeback queue directly upstream of the GPR register file's third write port (wen2/waddr2/waddr2_onehot/wd2).
- Buffers late results (non-blocking load returns, divider results) that cannot always win a write slot. Drains them in FIFO order whenever the port is free.
- Outputs both binary and one-hot destination addresses, so it feeds the regfile whether REGWRITE_SECURE is on or off.
- Provides a per-GPR pending scoreboard to decode for stall/bypass decisions.

Parameters:
- DEPTH, 4, number of queue entries (power of two, >=2).
- DEPTH_LOG2, 2, log2(DEPTH); width of pointers.

Ports:
- clk  input  1  core clock.
- rst_l  input  1  asynchronous active-low reset.
- push_valid  input  1  producer has a result.
- push_addr  input  5  destination GPR.
- push_data  input  32  result data.
- push_ready  output  1  queue can accept.
- port_free  input  1  regfile write port 2 unused by other writers this cycle.
- flush  input  1  discard all queued entries.
- wen2  output  1  write enable to regfile port 2.
- waddr2  output  5  binary write address.
- waddr2_onehot  output  32  one-hot write address, bit 0 never set.
- wd2  output  32  write data.
- pending  output  32  bit j set while any valid entry targets GPR j; bit 0 is always 0.
- count  output  DEPTH_LOG2+1  number of valid entries.

Behaviour:
- Reset (async, rst_l=0): rd/wr pointers=0, count=0, all entry valids=0. Outputs: push_ready=1, wen2=0, waddr2=0, waddr2_onehot=0, wd2=0, pending=0.
- Push: occurs when push_valid & push_ready. Entry is written at wr_ptr and wr_ptr increments modulo DEPTH, wrapping naturally.
- push_ready = (count != DEPTH). There is no same-cycle bypass.
- When full, push_ready=0 even if a pop happens in the same cycle. The producer must hold push_valid/addr/data until accepted.
- Push with push_addr==0 is accepted (handshake completes) but nothing is stored. count and pending are unchanged.
- Latency: a result pushed in cycle N can drive wen2 at earliest in cycle N+1.
- Drain: wen2 = (count!=0) & port_free & ~flush. waddr2, waddr2_onehot and wd2 come from the head entry.
  - When wen2=0, waddr2, waddr2_onehot and wd2 are forced to 0.
  - A pop happens when wen2=1: rd_ptr increments modulo DEPTH.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Ordering: strict FIFO. Two entries with the same destination both write, and the younger one lands last.
- pending: OR over valid entries of the one-hot address. Combinational from entry state.
  - An entry popped this cycle still shows in pending this cycle.
  - An entry pushed this cycle shows from the next cycle.
- flush: synchronous. On the next edge all valids clear, both pointers reset to 0 and count=0.
  - A push in the same cycle as flush is dropped.
  - While flush=1, wen2=0.
- Reset asserted mid-drain: wen2 drops immediately (async), and all state is lost.

Optional Feature:
- Macro: DEC_WBQ_ONEHOT_STORE_EN.
- Defined: each entry stores a 32-bit one-hot address decoded at push time. waddr2_onehot and pending are built from the stored vectors, so there is no decoder on the drain path.
- Undefined: the head's 5-bit address is decoded combinationally, and pending is decoded per entry.
- Port-visible behaviour is cycle-identical in both builds.

Decomposition:
- Package dec_wbq_pkg:
  - typedef wbq_entry_t (valid, addr[4:0], data[31:0], plus onehot[31:0] under the macro).
  - localparam GPR_NUM=32.
- Sub-module dec_wbq_onehot_dec: 5-to-32 decoder with bit 0 forced to 0. Instantiated at push (macro defined) or at head/per entry (macro undefined).

Test Plan:
- Reset, push addr=5/data=0xDEAD_BEEF, port_free=1 -> next cycle wen2=1, waddr2=5, waddr2_onehot=0x0000_0020, wd2=0xDEADBEEF. The cycle after: count=0, pending=0.
- port_free=0, push 4 entries (addr 1,2,3,4) -> count=4, push_ready=0, pending=0x0000_001E. A 5th push is held. Raise port_free -> drains in order 1,2,3,4 over 4 cycles, and the held push is accepted once count<4.
- Push addr=0 -> push_ready=1, count stays 0, wen2 never asserts.
- Push addr=7 data=A, then addr=7 data=B, with port_free=1 -> two writes to x7 in order A then B. pending[7] stays 1 until B is popped.
- Queue with 3 entries, assert flush together with push_valid -> wen2=0 that cycle. Next cycle count=0, pending=0, and the pushed data is never written.
- Fill to 2 entries, drop rst_l mid-drain -> wen2=0 immediately, all outputs at reset values. After release, the queue accepts pushes from an empty state, and pointer wrap is confirmed over 3×DEPTH pushes.
